// File: rtl/char_overlay.sv
// Single-line ASCII text overlay on an RGB video stream: tracks raster position,
// drives an external 8x16 glyph ROM and muxes fg/bg colour with delay-matched sync.
module char_overlay #(
    parameter int N_CHARS     = 16,
    parameter int PIX_W       = 24,
    parameter int CW          = 12,
    parameter int ROM_AW      = 11,
    parameter int ROM_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_vs,
    input  logic                       in_hs,
    input  logic                       in_de,
    input  logic [PIX_W-1:0]           in_data,
    input  logic                       overlay_en,
    input  logic [CW-1:0]              text_x,
    input  logic [CW-1:0]              text_y,
    input  logic [PIX_W-1:0]           fg_color,
    input  logic [PIX_W-1:0]           bg_color,
    input  logic                       bg_en,
    input  logic                       wr_en,
    input  logic [$clog2(N_CHARS)-1:0] wr_addr,
    input  logic [6:0]                 wr_char,
    output logic                       rom_re,
    output logic [ROM_AW-1:0]          rom_raddr,
    input  logic [7:0]                 rom_rdata,
    output logic                       out_vs,
    output logic                       out_hs,
    output logic                       out_de,
    output logic [PIX_W-1:0]           out_data
);
    localparam int AW = $clog2(N_CHARS);
    localparam logic [CW:0] WIN_W = (CW+1)'(8 * N_CHARS);
    localparam logic [CW:0] WIN_H = (CW+1)'(16);

    typedef struct packed {
        logic             vs;
        logic             hs;
        logic             de;
        logic             hit;
        logic [2:0]       col;
        logic [PIX_W-1:0] data;
    } stage_t;

    logic             vs_d, de_d, vs_rise;
    logic [CW-1:0]    x, y, tx_l, ty_l;
    logic [PIX_W-1:0] fg_l, bg_l;
    logic             bgen_l, en_l;
    logic [6:0]       tbuf [N_CHARS];

    assign vs_rise = in_vs & ~vs_d;

    // Window parameters are frame-stable: only the vsync rising edge loads them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d   <= 1'b0;
            de_d   <= 1'b0;
            x      <= '0;
            y      <= '0;
            tx_l   <= '0;
            ty_l   <= '0;
            fg_l   <= '0;
            bg_l   <= '0;
            bgen_l <= 1'b0;
            en_l   <= 1'b0;
        end else begin
            vs_d <= in_vs;
            de_d <= in_de;
            if (vs_rise) begin
                tx_l   <= text_x;
                ty_l   <= text_y;
                fg_l   <= fg_color;
                bg_l   <= bg_color;
                bgen_l <= bg_en;
                en_l   <= overlay_en;
            end
            x <= in_de ? ((&x) ? x : x + 1'b1) : '0;
            if (vs_rise)
                y <= '0;
            else if (de_d && !in_de && !(&y))
                y <= y + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CHARS; i++) tbuf[i] <= 7'h20;
        end else if (wr_en) begin
            tbuf[wr_addr] <= wr_char;
        end
    end

    // One extra bit on the offsets keeps a window near the right edge from wrapping.
    logic [CW:0]   dx, dy;
    logic          hit;
    logic [AW-1:0] slot;
    logic [6:0]    code;

    assign dx   = {1'b0, x} - {1'b0, tx_l};
    assign dy   = {1'b0, y} - {1'b0, ty_l};
    assign hit  = in_de & en_l & (x >= tx_l) & (dx < WIN_W) & (y >= ty_l) & (dy < WIN_H);
    assign slot = dx[AW+2:3];
    assign code = tbuf[slot];

    // pipe[0] is stage A; pipe[1..ROM_LATENCY] cover the ROM read latency.
    stage_t pipe [ROM_LATENCY+1];
    stage_t p;
    assign p = pipe[ROM_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= ROM_LATENCY; i++) pipe[i] <= '0;
            rom_re    <= 1'b0;
            rom_raddr <= '0;
        end else begin
            pipe[0] <= {in_vs, in_hs, in_de, hit, dx[2:0], in_data};
            for (int i = 1; i <= ROM_LATENCY; i++) pipe[i] <= pipe[i-1];
            rom_re <= hit;
            if (hit) rom_raddr <= ROM_AW'({code, dy[3:0]});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vs   <= 1'b0;
            out_hs   <= 1'b0;
            out_de   <= 1'b0;
            out_data <= '0;
        end else begin
            out_vs <= p.vs;
            out_hs <= p.hs;
            out_de <= p.de;
            if (p.hit && rom_rdata[3'd7 - p.col])
                out_data <= fg_l;
            else if (p.hit && bgen_l)
                out_data <= bg_l;
            else
                out_data <= p.data;
        end
    end
endmodule

// File: tb/tb_char_overlay.sv
// Self-checking bench for char_overlay: behavioural model pushes expected pixels and
// ROM addresses into queues, a negedge monitor pops and compares them.
module tb_char_overlay;
    localparam int RL  = 1;
    localparam int N   = 16;
    localparam int CW  = 12;
    localparam int LAT = 2 + RL;

    logic        clk, rst_n;
    logic        in_vs, in_hs, in_de, overlay_en, bg_en, wr_en;
    logic [23:0] in_data, fg_color, bg_color;
    logic [11:0] text_x, text_y;
    logic [3:0]  wr_addr;
    logic [6:0]  wr_char;
    logic        rom_re, out_vs, out_hs, out_de;
    logic [10:0] rom_raddr;
    logic [7:0]  rom_rdata;
    logic [23:0] out_data;

    char_overlay #(.N_CHARS(N), .PIX_W(24), .CW(CW), .ROM_AW(11), .ROM_LATENCY(RL)) dut (
        .clk(clk), .rst_n(rst_n), .in_vs(in_vs), .in_hs(in_hs), .in_de(in_de),
        .in_data(in_data), .overlay_en(overlay_en), .text_x(text_x), .text_y(text_y),
        .fg_color(fg_color), .bg_color(bg_color), .bg_en(bg_en), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_char(wr_char), .rom_re(rom_re), .rom_raddr(rom_raddr),
        .rom_rdata(rom_rdata), .out_vs(out_vs), .out_hs(out_hs), .out_de(out_de),
        .out_data(out_data));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Glyph ROM model: code 0x20 is blank, every other code a scrambled pattern.
    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        logic [7:0] v;
        if (a[10:4] == 7'h20) return 8'h00;
        v = a[7:0] * 8'd37;
        return v ^ {a[10:4], 1'b1} ^ 8'h5A;
    endfunction

    logic [7:0] rd1, rd2;
    always @(posedge clk) begin
        rd1 <= rom_fn(rom_raddr);
        rd2 <= rd1;
    end
    generate
        if (RL == 0) begin : g_rl0
            assign rom_rdata = rom_fn(rom_raddr);
        end else if (RL == 1) begin : g_rl1
            assign rom_rdata = rd1;
        end else begin : g_rl2
            assign rom_rdata = rd2;
        end
    endgenerate

    typedef struct packed { logic vs; logic hs; logic de; logic [23:0] d; } exp_t;
    typedef struct packed { logic re; logic [10:0] ra; } ra_t;
    exp_t q[$];
    ra_t  rq[$];
    exp_t me;
    ra_t  mr;
    int   nrun = 0, nfail = 0;
    bit   sb_on = 0;

    // Model state
    int          mx, my;
    logic [11:0] m_tx, m_ty;
    logic [23:0] m_fg, m_bg;
    logic        m_bgen, m_en, m_vsd, m_ded;
    logic [6:0]  mbuf [N];

    // Observation state
    int          first_re_x, last_ix, re_cnt, cap;
    logic [10:0] first_ra;
    logic [10:0] obs [2];

    always @(negedge clk) begin
        if (sb_on && rst_n) begin
            if (q.size() > LAT) begin
                me = q.pop_front();
                nrun++;
                if ({out_vs, out_hs, out_de, out_data} !== me) begin
                    nfail++;
                    $display("FAIL video @%0t: got vs/hs/de=%b%b%b data=%h, expected %b%b%b %h",
                             $time, out_vs, out_hs, out_de, out_data, me.vs, me.hs, me.de, me.d);
                end
            end
            if (rq.size() > 1) begin
                mr = rq.pop_front();
                nrun++;
                if (mr.re ? (rom_re !== 1'b1 || rom_raddr !== mr.ra) : (rom_re !== 1'b0)) begin
                    nfail++;
                    $display("FAIL rom_addr @%0t: got re=%b addr=%h, expected re=%b addr=%h",
                             $time, rom_re, rom_raddr, mr.re, mr.ra);
                end
            end
        end
    end

    task automatic model_reset();
        mx = 0; my = 0; m_tx = '0; m_ty = '0; m_fg = '0; m_bg = '0;
        m_bgen = 0; m_en = 0; m_vsd = 0; m_ded = 0;
        for (int i = 0; i < N; i++) mbuf[i] = 7'h20;
        q.delete(); rq.delete();
        cap = 0; last_ix = -1; first_re_x = -1; re_cnt = 0;
    endtask

    task automatic step(input logic vs, hs, de, input int ix,
                        input logic we, input logic [3:0] wa, input logic [6:0] wc);
        logic [23:0] d;
        exp_t        e;
        ra_t         r;
        int          dx, dy;
        logic [10:0] ra;
        logic [7:0]  bits;
        @(posedge clk); #1;
        if (rom_re) re_cnt++;
        if (rom_re && first_re_x < 0) begin first_re_x = last_ix; first_ra = rom_raddr; end
        if (cap > 0) begin obs[2-cap] = rom_raddr; cap--; end
        d = $urandom;
        in_vs = vs; in_hs = hs; in_de = de; in_data = d;
        wr_en = we; wr_addr = wa; wr_char = wc;
        last_ix = ix;
        if (we) cap = 2;
        dx = mx - int'(m_tx);
        dy = my - int'(m_ty);
        e = {vs, hs, de, d};
        r = '0;
        if (de && m_en && dx >= 0 && dx < 8*N && dy >= 0 && dy < 16) begin
            ra   = {mbuf[dx/8], 4'(dy)};
            bits = rom_fn(ra);
            r.re = 1'b1; r.ra = ra;
            if (bits[7 - (dx % 8)]) e.d = m_fg;
            else if (m_bgen)        e.d = m_bg;
        end
        q.push_back(e);
        rq.push_back(r);
        if (vs && !m_vsd) begin
            m_tx = text_x; m_ty = text_y; m_fg = fg_color; m_bg = bg_color;
            m_bgen = bg_en; m_en = overlay_en;
        end
        mx = de ? (mx < 4095 ? mx + 1 : mx) : 0;
        if (vs && !m_vsd)                       my = 0;
        else if (m_ded && !de && my < 4095)     my = my + 1;
        m_vsd = vs; m_ded = de;
        if (we) mbuf[wa] = wc;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, -1, 0, 0, 0);
    endtask

    task automatic frame(input int w, h, input bit with_vs, input int chg_line, chg_x,
                         input int wr_line, wr_x, input logic [3:0] wa, input logic [6:0] wc);
        if (with_vs) repeat (2) step(1, 0, 0, -1, 0, 0, 0);
        idle(2);
        for (int l = 0; l < h; l++) begin
            if (l == chg_line) text_x = 12'(chg_x);
            repeat (2) step(0, 1, 0, -1, 0, 0, 0);
            idle(2);
            for (int i = 0; i < w; i++)
                step(0, 0, 1, i, (l == wr_line && i == wr_x), wa, wc);
            idle(2);
        end
        idle(LAT + 2);
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        nrun++;
        if ({out_vs, out_hs, out_de, out_data} !== 27'd0) begin
            nfail++; $display("FAIL reset_outputs: got %b%b%b %h, expected all 0", out_vs, out_hs, out_de, out_data);
        end
        nrun++;
        if (rom_re !== 1'b0 || rom_raddr !== 11'd0) begin
            nfail++; $display("FAIL reset_rom: got re=%b addr=%h, expected 0 0", rom_re, rom_raddr);
        end
        rst_n = 1;
        sb_on = 1;
        // Mid-frame reset: overlay active, then pull reset inside a line.
        text_x = 0; text_y = 0; overlay_en = 1; bg_en = 1; bg_color = 24'h123456;
        repeat (2) step(1, 0, 0, -1, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 10; i++) step(0, 0, 1, i, 0, 0, 0);
        sb_on = 0;
        #2 rst_n = 0;
        #1;
        nrun++;
        if ({out_vs, out_hs, out_de, out_data, rom_re} !== 28'd0) begin
            nfail++; $display("FAIL midframe_reset: got de=%b data=%h re=%b, expected 0", out_de, out_data, rom_re);
        end
        in_vs = 0; in_hs = 0; in_de = 0; in_data = 0; wr_en = 0;
        model_reset();
        #10 rst_n = 1;
        sb_on = 1;
        frame(32, 20, 0, -1, 0, -1, 0, 0, 0);
        nrun++;
        if (re_cnt !== 0) begin
            nfail++; $display("FAIL overlay_off_after_reset: got %0d rom reads, expected 0", re_cnt);
        end
    endtask

    task automatic test_glyph_a();
        step(0, 0, 0, -1, 1, 4'd0, 7'h41);
        text_x = 16; text_y = 8; fg_color = 24'hFFFFFF; bg_color = 24'h0; bg_en = 0; overlay_en = 1;
        first_re_x = -1;
        frame(64, 32, 1, -1, 0, -1, 0, 0, 0);
        nrun++;
        if (first_re_x !== 16 || first_ra !== 11'h410) begin
            nfail++; $display("FAIL glyph_first_read: got x=%0d addr=%h, expected x=16 addr=410", first_re_x, first_ra);
        end
    endtask

    task automatic test_bg_box();
        step(0, 0, 0, -1, 1, 4'd0, 7'h20);
        bg_en = 1; bg_color = 24'h000080;
        re_cnt = 0;
        frame(160, 28, 1, -1, 0, -1, 0, 0, 0);
        nrun++;
        if (re_cnt !== 2048) begin
            nfail++; $display("FAIL bg_box_reads: got %0d, expected 2048", re_cnt);
        end
    endtask

    task automatic test_midframe_pos();
        step(0, 0, 0, -1, 1, 4'd1, 7'h4B);
        text_x = 16; first_re_x = -1;
        frame(64, 26, 1, 4, 40, -1, 0, 0, 0);
        nrun++;
        if (first_re_x !== 16) begin
            nfail++; $display("FAIL midframe_same_frame: got x=%0d, expected 16", first_re_x);
        end
        first_re_x = -1;
        frame(64, 26, 1, -1, 0, -1, 0, 0, 0);
        nrun++;
        if (first_re_x !== 40) begin
            nfail++; $display("FAIL midframe_next_frame: got x=%0d, expected 40", first_re_x);
        end
    endtask

    task automatic test_wr_collision();
        step(0, 0, 0, -1, 1, 4'd3, 7'h41);
        text_x = 16; text_y = 8; bg_en = 0;
        frame(64, 12, 1, -1, 0, 10, 40, 4'd3, 7'h42);
        nrun++;
        if (obs[0] !== 11'h412 || obs[1] !== 11'h422) begin
            nfail++; $display("FAIL wr_collision: got %h then %h, expected 412 then 422", obs[0], obs[1]);
        end
    endtask

    task automatic test_no_wrap();
        text_x = 12'd4092; text_y = 0; bg_en = 1;
        re_cnt = 0;
        frame(64, 20, 1, -1, 0, -1, 0, 0, 0);
        nrun++;
        if (re_cnt !== 0) begin
            nfail++; $display("FAIL no_wrap: got %0d rom reads, expected 0", re_cnt);
        end
    endtask

    task automatic test_latency();
        int lv, lh, ld;
        logic [23:0] dat;
        sb_on = 0;
        rst_n = 0;
        #10 rst_n = 1;
        model_reset();
        lv = -1; lh = -1; ld = -1; dat = '0;
        @(posedge clk); #1;
        in_vs = 1; in_hs = 1; in_de = 1; in_data = 24'hC0FFEE;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin in_vs = 0; in_hs = 0; in_de = 0; in_data = 0; end
            if (out_vs && lv < 0) lv = k;
            if (out_hs && lh < 0) lh = k;
            if (out_de && ld < 0) begin ld = k; dat = out_data; end
        end
        nrun++;
        if (lv !== LAT || lh !== LAT || ld !== LAT) begin
            nfail++; $display("FAIL latency: got vs=%0d hs=%0d de=%0d, expected %0d", lv, lh, ld, LAT);
        end
        nrun++;
        if (dat !== 24'hC0FFEE) begin
            nfail++; $display("FAIL latency_data: got %h, expected c0ffee", dat);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 0; in_vs = 0; in_hs = 0; in_de = 0; in_data = 0;
        overlay_en = 0; text_x = 0; text_y = 0; fg_color = 0; bg_color = 0; bg_en = 0;
        wr_en = 0; wr_addr = 0; wr_char = 0;
        model_reset();
        test_reset();
        test_glyph_a();
        test_bg_box();
        test_midframe_pos();
        test_wr_collision();
        test_no_wrap();
        test_latency();
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end
endmodule

// File: doc/char_overlay.md
Name: char_overlay

Overview:
- Renders a single line of ASCII text onto a live RGB video stream.
- Sits upstream of the glyph ROM (8x16 font, one byte per glyph row). It tracks raster position, holds a small host-writable text buffer, generates ROM read addresses, and consumes ROM row data.
- It then muxes foreground/background colour into the pixel stream, with all video control signals delay-matched.
- Placed in the video pipeline after scaling, before the display output stage.

Parameters:
- N_CHARS, 16, characters in the text buffer/line (power of two, 2..64)
- PIX_W, 24, pixel data width (RGB888)
- CW, 12, coordinate width for x/y counters and position inputs
- ROM_AW, 11, glyph ROM address width ({code[6:0], row[3:0]})
- ROM_LATENCY, 1, clocks from rom_raddr change to valid rom_rdata (0..2)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- in_vs  in  1  vsync, active high
- in_hs  in  1  hsync, active high
- in_de  in  1  data enable
- in_data  in  PIX_W  input pixel
- overlay_en  in  1  overlay enable
- text_x  in  CW  left pixel of text window
- text_y  in  CW  top line of text window
- fg_color  in  PIX_W  glyph colour
- bg_color  in  PIX_W  box colour
- bg_en  in  1  fill non-glyph window pixels with bg_color
- wr_en  in  1  text buffer write strobe
- wr_addr  in  log2(N_CHARS)  character slot
- wr_char  in  7  ASCII code
- rom_re  out  1  ROM read enable
- rom_raddr  out  ROM_AW  ROM address
- rom_rdata  in  8  glyph row, bit 7 = leftmost pixel
- out_vs  out  1  delayed vsync
- out_hs  out  1  delayed hsync
- out_de  out  1  delayed de
- out_data  out  PIX_W  overlaid pixel

Behaviour:
- Reset (async, rst_n=0): all outputs 0; counters 0; every text buffer slot = 0x20 (space); latched position/colour/enable = 0.
- Frame latch: on the in_vs rising edge, capture text_x, text_y, fg_color, bg_color, bg_en and overlay_en. Capture only at this edge; mid-frame changes take effect next frame.
- x counter: increments each in_de=1 cycle from 0; clears on the cycle after in_de falls. Saturates at 2^CW-1, no wrap.
- y counter: increments once per in_de falling edge; clears on the in_vs rising edge. Saturates at 2^CW-1.
- Window hit: dx = x - text_x, dy = y - text_y.
  - hit = in_de and overlay_en_latched and x >= text_x and dx < 8*N_CHARS and y >= text_y and dy < 16.
  - Comparisons are unsigned, with CW+1-bit intermediates so text_x near max does not wrap.
- Stage A (registered):
  - rom_raddr = {buf[dx>>3], dy[3:0]}; rom_re = hit.
  - Carry the bit column dx[2:0], hit, and the video signals alongside.
  - Outside a hit, rom_raddr holds its last value.
- ROM wait: the carried signals are delayed by ROM_LATENCY stages.
- Output stage (registered):
  - If hit and rom_rdata[7-col] = 1: out_data = fg_color.
  - Else if hit and bg_en: out_data = bg_color.
  - Else: out_data = delayed in_data.
  - Outside de, out_data passes through unchanged.
- Latency: in_* to out_* is exactly 2+ROM_LATENCY clocks (default 3), for all four video signals identically. No bubbles; throughput is 1 pixel/clk.
- Text buffer:
  - Register file. A write on wr_en is visible to Stage A reads from the next clock.
  - A write to a slot being rendered the same cycle: the current pixel uses the old code.
  - Writes are accepted at any time, including mid-line.
  - wr_char bit 7 does not exist; codes 0x00..0x7F are all legal.
- Window clipping: a window extending past the active width or height is clipped naturally; there is no wrap to the next line.
- Reset mid-frame: outputs go to 0 immediately. After release, counters restart at 0 and the overlay stays off until the next in_vs rising edge latches overlay_en.

Test Plan:
- Reset release, wr slot0 = 0x41, text_x=16, text_y=8, fg=0xFFFFFF, bg_en=0, overlay_en=1, one vsync then a 64x32 frame:
  - rom_raddr = 0x410+dy for x=16..23, y=8..23.
  - out_data = fg where the model 'A' glyph bit = 1, else in_data.
  - Latency exactly 3 clk.
- bg_en=1, bg=0x000080, all slots = 0x20 (blank glyph):
  - Every pixel x=16..16+127, y=8..23 = 0x000080.
  - Pixels x=15, x=144, y=7 and y=24 = in_data.
- text_x changed mid-frame from 16 to 40 -> current frame still renders at 16; next frame at 40.
- wr_en to slot 3 on the exact cycle Stage A reads slot 3 -> that pixel uses the old code, the following pixel the new code.
- text_x = 2^CW-4 -> no false hits at x=0..3 (no wraparound); out_data = in_data everywhere.
- ROM_LATENCY=0 and 2 builds -> end-to-end latency 2 and 4 clk; out_vs/hs/de match in_* delayed by the same amount.
